hyperbus_trans_chop: RTL

- Sits between the AXI-side transfer generator and the PHY transfer CDC, in the system clock domain.
- Splits each HyperBus transfer into sub-transfers that never cross a page boundary and never exceed a runtime-programmable maximum burst.
- Merges the per-sub-transfer write responses back into one response per original transfer.
- Successor to the single-transfer pass-through path: adds page-aware chopping, a burst limit and outstanding-response tracking.

---
 rtl/hyperbus_trans_chop.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_trans_chop.sv
// Splits HyperBus transfers at page boundaries and at a programmable burst
// limit. It also merges the per-chunk write responses into one response per
// original transfer.
// Ports:
//   in_*  : original transfer (valid/ready)
//   out_* : sub-transfers to the PHY CDC (valid/ready)
//   b_*_i : per-chunk write responses
//   b_*_o : merged write responses
module hyperbus_trans_chop #(
  parameter int NumChips       = 2,
  parameter int AddrWidth      = 32,
  parameter int LenWidth       = 16,
  parameter int PageWords      = 512,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LenWidth-1:0]  max_burst_i,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic                 in_write_i,
  input  logic [NumChips-1:0]  in_cs_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [LenWidth-1:0]  out_len_o,
  output logic                 out_write_o,
  output logic [NumChips-1:0]  out_cs_o,
  output logic                 out_last_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 b_error_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  output logic                 b_error_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i
);

  localparam int CW       = LenWidth + 1;
  localparam int PageBits = $clog2(PageWords);
  localparam int CntW     = $clog2(MaxOutstanding + 1);
  localparam int PtrW     = (MaxOutstanding > 1) ?
                            $clog2(MaxOutstanding) : 1;
  localparam logic [CW-1:0]   One   = 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxOutstanding - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [CW-1:0]        rem_q;
  logic                 write_q;
  logic [NumChips-1:0]  cs_q;

  logic [CW-1:0] page_left;
  logic [CW-1:0] burst;
  logic [CW-1:0] chunk;
  logic [CW-1:0] len_m1;
  logic          issue;
  logic          out_hs;

  logic            fifo_mem [2**PtrW];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] cnt;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            pop_flag;

  logic acc_q;
  logic b_valid_q;
  logic b_error_q;

  // Largest chunk allowed by remaining length, page end and burst limit
  always_comb begin
    page_left = CW'(PageWords) - CW'(addr_q[PageBits-1:0]);
    burst     = {1'b0, max_burst_i};
    chunk     = rem_q;
    if (page_left < chunk) chunk = page_left;
    if (burst != '0 && burst < chunk) chunk = burst;
    len_m1    = chunk - One;
  end

  assign issue     = (state_q == ISSUE);
  assign fifo_full = (cnt == CntMax);

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = issue & ~(write_q & fifo_full);
  assign out_addr_o  = issue ? addr_q : '0;
  assign out_len_o   = issue ? len_m1[LenWidth-1:0] : '0;
  assign out_last_o  = issue & (chunk == rem_q);
  assign out_write_o = issue & write_q;
  assign out_cs_o    = issue ? cs_q : '0;

  assign out_hs = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = ISSUE;
      ISSUE:   if (out_hs && out_last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      rem_q   <= '0;
      write_q <= 1'b0;
      cs_q    <= '0;
    end else if (in_ready_o && in_valid_i) begin
      addr_q  <= in_addr_i;
      rem_q   <= {1'b0, in_len_i} + One;
      write_q <= in_write_i;
      cs_q    <= in_cs_i;
    end else if (out_hs) begin
      addr_q  <= addr_q + AddrWidth'(chunk);
      rem_q   <= rem_q - chunk;
    end
  end

  // Tracking FIFO: one "last" flag per outstanding write chunk
  assign push      = out_hs & write_q;
  assign b_ready_o = (cnt != '0) & ~b_valid_q;
  assign pop       = b_valid_i & b_ready_o;
  assign pop_flag  = fifo_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= out_last_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PtrMax) ? '0 : wr_ptr + PtrOne;
      if (pop)  rd_ptr <= (rd_ptr == PtrMax) ? '0 : rd_ptr + PtrOne;
      if (push && !pop)      cnt <= cnt + CntOne;
      else if (pop && !push) cnt <= cnt - CntOne;
    end
  end

  // Error accumulation across chunks; emit on the final chunk's response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= 1'b0;
      b_valid_q <= 1'b0;
      b_error_q <= 1'b0;
    end else begin
      if (b_valid_q && b_ready_i) b_valid_q <= 1'b0;
      if (pop) begin
        if (pop_flag) begin
          b_valid_q <= 1'b1;
          b_error_q <= acc_q | b_error_i;
          acc_q     <= 1'b0;
        end else begin
          acc_q     <= acc_q | b_error_i;
        end
      end
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_error_o = b_error_q;

endmodule
